// File: rtl/uart_receiver_pkg.sv
// Shared UART frame definitions: parity modes, receiver states and the parity rule
// common to the transmitter and receiver.
package uart_receiver_pkg;

   localparam logic [1:0] PARITY_SPACE = 2'b00;
   localparam logic [1:0] PARITY_ODD   = 2'b01;
   localparam logic [1:0] PARITY_EVEN  = 2'b10;
   localparam logic [1:0] PARITY_MARK  = 2'b11;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_PAR   = 3'd3,
      RX_STOP  = 3'd4
   } rx_state_e;

   // Parity over the active data bits only; dataBits encodes bit count minus 5.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [1:0] data_bits,
                                       input logic [1:0] mode);
      logic [7:0] mask;
      logic [7:0] masked;
      logic       result;
      mask   = ~(8'hFF << (4'(data_bits) + 4'd5));
      masked = data & mask;
      case (mode)
         PARITY_SPACE: result = 1'b0;
         PARITY_MARK:  result = 1'b1;
         PARITY_EVEN:  result = ^masked;
         PARITY_ODD:   result = ~^masked;
         default:      result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
// All flops reset high so an idle line never looks like a start edge.
module uart_rx_synchronizer (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync,
   output logic fall_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = rx;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rx_sync = sync_q;
   assign fall_c  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: samples each bit at its centre, assembles the character and hands it
// over through a one-deep holding register with parity/framing/overrun status.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLOCK_DIVISOR_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rx,
   input  logic [1:0]                     dataBits,
   input  logic                           hasParity,
   input  logic [1:0]                     parityMode,
   input  logic                           extraStopBit,
   input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
   output logic [7:0]                     data,
   output logic                           valid,
   input  logic                           ack,
   output logic                           parityError,
   output logic                           frameError,
   output logic                           overrun
);

   localparam int unsigned CNT_W = CLOCK_DIVISOR_WIDTH + 1;

   localparam logic [2:0] S_IDLE  = 3'(RX_IDLE);
   localparam logic [2:0] S_START = 3'(RX_START);
   localparam logic [2:0] S_DATA  = 3'(RX_DATA);
   localparam logic [2:0] S_PAR   = 3'(RX_PAR);
   localparam logic [2:0] S_STOP  = 3'(RX_STOP);

   logic rx_sync;
   logic fall_c;

   uart_rx_synchronizer u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_sync (rx_sync),
      .fall_c  (fall_c)
   );

   logic [2:0]                     state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [CLOCK_DIVISOR_WIDTH-1:0] div_q, div_d;
   logic [1:0]                     data_bits_q, data_bits_d;
   logic                           has_parity_q, has_parity_d;
   logic [1:0]                     parity_mode_q, parity_mode_d;
   logic                           extra_stop_q, extra_stop_d;
   logic [2:0]                     bit_idx_q, bit_idx_d;
   logic                           stop_idx_q, stop_idx_d;
   logic [7:0]                     shift_q, shift_d;
   logic                           par_err_q, par_err_d;
   logic                           frm_err_q, frm_err_d;
   logic [7:0]                     data_q, data_d;
   logic                           valid_q, valid_d;
   logic                           parity_error_q, parity_error_d;
   logic                           frame_error_q, frame_error_d;
   logic                           overrun_q, overrun_d;

   logic             tick_c;
   logic [CNT_W-1:0] period_m1_c;
   logic             frame_fe_c;

   // Next-state, bit-timing and holding-register logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      div_d          = div_q;
      data_bits_d    = data_bits_q;
      has_parity_d   = has_parity_q;
      parity_mode_d  = parity_mode_q;
      extra_stop_d   = extra_stop_q;
      bit_idx_d      = bit_idx_q;
      stop_idx_d     = stop_idx_q;
      shift_d        = shift_q;
      par_err_d      = par_err_q;
      frm_err_d      = frm_err_q;
      data_d         = data_q;
      valid_d        = valid_q;
      parity_error_d = parity_error_q;
      frame_error_d  = frame_error_q;
      overrun_d      = 1'b0;

      tick_c      = (cnt_q == '0);
      period_m1_c = {div_q, 1'b1};
      frame_fe_c  = frm_err_q | ~rx_sync;

      if (valid_q && ack) valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fall_c) begin
               state_d       = S_START;
               cnt_d         = CNT_W'(clockDivisor);
               div_d         = clockDivisor;
               data_bits_d   = dataBits;
               has_parity_d  = hasParity;
               parity_mode_d = parityMode;
               extra_stop_d  = extraStopBit;
               bit_idx_d     = '0;
               stop_idx_d    = 1'b0;
               shift_d       = '0;
               par_err_d     = 1'b0;
               frm_err_d     = 1'b0;
            end
         end
         S_START: begin
            if (!tick_c) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rx_sync) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DATA;
               cnt_d   = period_m1_c;
            end
         end
         S_DATA: begin
            if (!tick_c) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d[bit_idx_q] = rx_sync;
               cnt_d              = period_m1_c;
               if (bit_idx_q == 3'(data_bits_q) + 3'd4) begin
                  state_d = has_parity_q ? S_PAR : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PAR: begin
            if (!tick_c) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               par_err_d = (rx_sync != parity_bit(shift_q, data_bits_q, parity_mode_q));
               state_d   = S_STOP;
               cnt_d     = period_m1_c;
            end
         end
         S_STOP: begin
            if (!tick_c) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (extra_stop_q && !stop_idx_q) begin
               frm_err_d  = frame_fe_c;
               stop_idx_d = 1'b1;
               cnt_d      = period_m1_c;
            end else begin
               // Last stop sample: hand over, or drop the frame if the holder is busy.
               state_d   = S_IDLE;
               frm_err_d = frame_fe_c;
               if (!valid_q || ack) begin
                  data_d         = shift_q;
                  parity_error_d = par_err_q;
                  frame_error_d  = frame_fe_c;
                  valid_d        = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         div_q          <= '0;
         data_bits_q    <= '0;
         has_parity_q   <= 1'b0;
         parity_mode_q  <= '0;
         extra_stop_q   <= 1'b0;
         bit_idx_q      <= '0;
         stop_idx_q     <= 1'b0;
         shift_q        <= '0;
         par_err_q      <= 1'b0;
         frm_err_q      <= 1'b0;
         data_q         <= '0;
         valid_q        <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         div_q          <= div_d;
         data_bits_q    <= data_bits_d;
         has_parity_q   <= has_parity_d;
         parity_mode_q  <= parity_mode_d;
         extra_stop_q   <= extra_stop_d;
         bit_idx_q      <= bit_idx_d;
         stop_idx_q     <= stop_idx_d;
         shift_q        <= shift_d;
         par_err_q      <= par_err_d;
         frm_err_q      <= frm_err_d;
         data_q         <= data_d;
         valid_q        <= valid_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         overrun_q      <= overrun_d;
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign parityError = parity_error_q;
   assign frameError  = frame_error_q;
   assign overrun     = overrun_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for the line side, the counterpart of the UART transmitter. It shares the transmitter's frame configuration inputs and bit-period definition, so a loopback from transmitter `tx` to receiver `rx` with identical settings round-trips every frame. It delivers each received character through a one-deep holding register, with parity, framing and overrun status.

## Interface
- CLOCK_DIVISOR_WIDTH, 24, width of `clockDivisor`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- dataBits  in  2  data bit count minus 5 (0→5 … 3→8).
- hasParity  in  1  a parity bit follows the data bits.
- parityMode  in  2  00 space, 11 mark, 10 even, 01 odd.
- extraStopBit  in  1  two stop bits instead of one.
- clockDivisor  in  CLOCK_DIVISOR_WIDTH  bit period P = 2·(clockDivisor+1) clk cycles; legal values are ≥1.
- data  out  8  received character, LSB = first bit received; unused high bits are 0.
- valid  out  1  `data` and the error flags are held and valid.
- ack  in  1  consumer accepts the held character; clears `valid`.
- parityError  out  1  parity mismatch for the held character.
- frameError  out  1  a stop bit sampled low for the held character.
- overrun  out  1  one-cycle pulse when a completed frame was dropped.

## Operation
- `rx` passes through a 2-flop synchronizer (flops reset to 1), followed by an edge-detect flop. Start detection is a 1→0 transition of the synchronized line in IDLE only.
- All configuration inputs are latched on the start-detect cycle. Changes mid-frame have no effect.
- States:
  - IDLE → START on falling edge.
  - START: wait H = clockDivisor+1 cycles to the bit centre, then sample.
    - Sample high: false start, return to IDLE, nothing reported.
    - Sample low: go to DATA.
  - DATA: sample every P cycles, shifting LSB-first. Take dataBits+5 samples, then go to PAR if parity is enabled, else STOP.
  - PAR: one sample, compared against the expected parity. Expected parity is computed over the masked data bits only: even = XOR, odd = XNOR, space = 0, mark = 1.
  - STOP: one sample, or two samples P apart when extraStopBit is set. Any low sample sets the frame error. After the last stop sample, go to IDLE.
- Completion, on the cycle after the last stop sample:
  - If `valid`=0, or `ack`=1 in that same cycle: load `data`, `parityError` and `frameError`, and set `valid`=1.
  - Otherwise: pulse `overrun`, drop the new frame, and leave the held character untouched.
- `ack` while `valid`=0 is ignored. `ack` clears `valid` only; `data` and the flags keep their last values.
- Returning to IDLE at the stop-bit centre gives half a bit of slack for resynchronisation. A falling edge on the next cycle starts a new frame.
- A low line held through a stop bit (break) yields a frame with `frameError`=1 and data 0. The receiver then waits for the line to go high before it can detect the next start.

## Timing
- Reset values:
  - Outputs: `data`=0, `valid`=0, `parityError`=0, `frameError`=0, `overrun`=0.
  - Internal: state IDLE, synchronizer flops = 1.
- Reset mid-frame aborts the frame silently. Nothing is reported, and a new start edge is required.
- Let cycle 0 be the cycle the edge is detected on the synchronized signal. Then:
  - Start sample at cycle H.
  - Data bit k sampled at cycle H + (k+1)·P.
  - Parity and stop samples follow at successive multiples of P.
- `valid` rises 1 cycle after the last stop sample. From the rx pin, add 3 cycles of synchronizer/edge latency.
- Completion and `ack` in the same cycle: the new character is loaded and `valid` stays 1, with no overrun.

## Structure
- Shared package holds:
  - The parity mode constants (SPACE=00, ODD=01, EVEN=10, MARK=11).
  - The receiver state enum (IDLE, START, DATA, PAR, STOP).
  - A parity function (data, dataBits, mode) using mask ~(8'hFF << (dataBits+5)), identical to the transmitter's rule.
- Sub-module `uart_rx_synchronizer`: 2-flop synchronizer plus falling-edge detect, with reset value 1.
- Bit-period counter and state machine live in the top level. Estimated size ~200 lines.

## Test plan
- Loopback: 8N1, clockDivisor=3 (P=8), transmit 0xA5 → `valid`=1, `data`=0xA5, both error flags 0, `valid` cleared by `ack`.
- 7E2, clockDivisor=5, send 0x53 with correct parity bit 0 → `data`=0x53, `parityError`=0. Repeat with the parity bit forced to 1 → `parityError`=1.
- 5O1 (dataBits=0), send 0xFF pattern → `data`=0x1F (upper bits 0). A stop bit driven low → `frameError`=1.
- Glitch: `rx` low for H−2 cycles then high → no `valid`, state back in IDLE, and the next real frame 0x3C is received correctly.
- Two back-to-back frames 0x11, 0x22 with no `ack` → `data` stays 0x11 and `overrun` pulses once. Repeat with `ack` on the completion cycle → `data`=0x22 and no overrun.
- Assert `rst` during data bit 3 of a frame → all outputs return to reset values, no `valid` appears, and the following frame 0x81 is received cleanly.
